// File: rtl/any1_pkg.sv
// Shared ANY-1 front-end types and constants: the aligner input bundle,
// the fetch controller state encoding and the fetch reset/increment values.
package any1_pkg;

  localparam int ANY1_AWID      = 32;
  localparam int ANY1_LINE_BITS = 512;

  localparam logic [ANY1_AWID-1:0] INSN_BYTES = 32'd4;
  localparam logic [ANY1_AWID-1:0] RSTIP      = 32'hFFFC0100;

  typedef struct packed {
    logic                      v;
    logic                      predict_taken;
    logic [ANY1_LINE_BITS-1:0] cacheline;
    logic [ANY1_AWID-1:0]      ip;
    logic [ANY1_AWID-1:0]      pip;
  } sInstAlignIn;

  typedef enum logic [1:0] {
    IFS_RUN        = 2'd0,
    IFS_FILL       = 2'd1,
    IFS_FILL_ABORT = 2'd2
  } e_ifetch_state;

endpackage

// File: rtl/any1_sat_counter.sv
// Saturating up-counter with synchronous clear, used for front-end
// performance counters such as I-cache misses.
module any1_sat_counter #(
  parameter int WID = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inc,
  input  logic           clear,
  output logic [WID-1:0] count
);

  localparam logic [WID-1:0] ONE = {{(WID-1){1'b0}}, 1'b1};

  // Sticks at all-ones so a long run never wraps back to a small value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/any1_ifetch_ctrl.sv
// ANY-1 instruction fetch sequencer: owns the fetch IP, runs the I-cache
// miss/line-fill handshake, applies BTB predictions and redirects.
module any1_ifetch_ctrl
  import any1_pkg::*;
#(
  parameter int AWID      = ANY1_AWID,
  parameter int LINE_BITS = ANY1_LINE_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 redirect_i,
  input  logic [AWID-1:0]      redirect_ip_i,
  input  logic                 btb_hit_i,
  input  logic [AWID-1:0]      btb_tgt_i,
  output logic [AWID-1:0]      ic_adr_o,
  input  logic                 ic_hit_i,
  input  logic [LINE_BITS-1:0] ic_line_i,
  output logic                 fill_req_o,
  output logic [AWID-1:0]      fill_adr_o,
  input  logic                 fill_done_i,
  output sInstAlignIn          al_o,
  input  logic                 al_ready_i,
  output logic [31:0]          miss_cnt_o
);

  e_ifetch_state state_q, state_n;
  logic [AWID-1:0] ip_q, ip_n;
  logic [AWID-1:0] pip_q, pip_n;
  sInstAlignIn     al_q, al_n;
  logic            fill_req_q, fill_req_n;
  logic [AWID-1:0] fill_adr_q, fill_adr_n;
  logic            miss_inc;
  logic            consumed;
  logic            advance;

  assign consumed = al_q.v & al_ready_i;
  assign advance  = ic_hit_i & (~al_q.v | al_ready_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IFS_RUN;
      ip_q       <= RSTIP;
      pip_q      <= RSTIP;
      al_q       <= '0;
      fill_req_q <= 1'b0;
      fill_adr_q <= '0;
    end else begin
      state_q    <= state_n;
      ip_q       <= ip_n;
      pip_q      <= pip_n;
      al_q       <= al_n;
      fill_req_q <= fill_req_n;
      fill_adr_q <= fill_adr_n;
    end
  end

  // A redirect pre-empts everything; an in-flight fill is still allowed to
  // finish, so FILL_ABORT keeps the request up but discards nothing else.
  always_comb begin
    state_n    = state_q;
    ip_n       = ip_q;
    pip_n      = pip_q;
    al_n       = al_q;
    fill_req_n = fill_req_q;
    fill_adr_n = fill_adr_q;
    miss_inc   = 1'b0;

    if (redirect_i) begin
      ip_n   = redirect_ip_i;
      pip_n  = redirect_ip_i;
      al_n.v = 1'b0;
      if (state_q != IFS_RUN) begin
        if (fill_done_i) begin
          fill_req_n = 1'b0;
          state_n    = IFS_RUN;
        end else begin
          state_n = IFS_FILL_ABORT;
        end
      end
    end else begin
      case (state_q)
        IFS_RUN: begin
          if (advance) begin
            al_n.v             = 1'b1;
            al_n.predict_taken = btb_hit_i;
            al_n.cacheline     = ic_line_i;
            al_n.ip            = ip_q;
            al_n.pip           = pip_q;
            pip_n              = ip_q;
            ip_n               = btb_hit_i ? btb_tgt_i : ip_q + INSN_BYTES;
          end else begin
            if (consumed) begin
              al_n.v = 1'b0;
            end
            if (!ic_hit_i) begin
              state_n    = IFS_FILL;
              fill_req_n = 1'b1;
              fill_adr_n = {ip_q[AWID-1:6], 6'b0};
              miss_inc   = 1'b1;
            end
          end
        end
        default: begin
          if (consumed) begin
            al_n.v = 1'b0;
          end
          if (fill_done_i) begin
            fill_req_n = 1'b0;
            state_n    = IFS_RUN;
          end
        end
      endcase
    end
  end

  any1_sat_counter #(
    .WID(32)
  ) u_miss_cnt (
    .clk  (clk_i),
    .rst  (rst_i),
    .inc  (miss_inc),
    .clear(1'b0),
    .count(miss_cnt_o)
  );

  assign ic_adr_o   = ip_q;
  assign al_o       = al_q;
  assign fill_req_o = fill_req_q;
  assign fill_adr_o = fill_adr_q;

endmodule

// File: tb/tb_any1_ifetch_ctrl.sv
// Cycle-by-cycle directed vectors for any1_ifetch_ctrl, plus a hand-written
// reset-in-the-middle-of-a-fill sequence.
module tb_any1_ifetch_ctrl;
  import any1_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         redirect_i;
  logic [31:0]  redirect_ip_i;
  logic         btb_hit_i;
  logic [31:0]  btb_tgt_i;
  logic [31:0]  ic_adr_o;
  logic         ic_hit_i;
  logic [511:0] ic_line_i;
  logic         fill_req_o;
  logic [31:0]  fill_adr_o;
  logic         fill_done_i;
  sInstAlignIn  al_o;
  logic         al_ready_i;
  logic [31:0]  miss_cnt_o;

  int n_compared = 0;
  int n_failed   = 0;

  typedef struct {
    logic        rd;
    logic [31:0] rdip;
    logic        btb;
    logic [31:0] tgt;
    logic        hit;
    logic        done;
    logic        rdy;
    logic        ev;
    logic        ept;
    logic [31:0] eip;
    logic [31:0] epip;
    logic [31:0] eadr;
    logic        efreq;
    logic [31:0] efadr;
    logic [31:0] ecnt;
  } vec_t;

  localparam int NVEC = 31;
  vec_t vecs [NVEC];

  any1_ifetch_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .redirect_i   (redirect_i),
    .redirect_ip_i(redirect_ip_i),
    .btb_hit_i    (btb_hit_i),
    .btb_tgt_i    (btb_tgt_i),
    .ic_adr_o     (ic_adr_o),
    .ic_hit_i     (ic_hit_i),
    .ic_line_i    (ic_line_i),
    .fill_req_o   (fill_req_o),
    .fill_adr_o   (fill_adr_o),
    .fill_done_i  (fill_done_i),
    .al_o         (al_o),
    .al_ready_i   (al_ready_i),
    .miss_cnt_o   (miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Cache model: each line is tagged with the lookup address so the
  // captured cacheline shows which lookup produced it.
  assign ic_line_i = {16{ic_adr_o}};

  function automatic vec_t mk(logic rd, logic [31:0] rdip, logic btb, logic [31:0] tgt,
                              logic hit, logic done, logic rdy, logic ev, logic ept,
                              logic [31:0] eip, logic [31:0] epip, logic [31:0] eadr,
                              logic efreq, logic [31:0] efadr, logic [31:0] ecnt);
    vec_t v;
    v.rd = rd; v.rdip = rdip; v.btb = btb; v.tgt = tgt; v.hit = hit; v.done = done;
    v.rdy = rdy; v.ev = ev; v.ept = ept; v.eip = eip; v.epip = epip; v.eadr = eadr;
    v.efreq = efreq; v.efadr = efadr; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    redirect_i    = v.rd;
    redirect_ip_i = v.rdip;
    btb_hit_i     = v.btb;
    btb_tgt_i     = v.tgt;
    ic_hit_i      = v.hit;
    fill_done_i   = v.done;
    al_ready_i    = v.rdy;
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [511:0] act, input logic [511:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    logic [511:0] exp_line;
    exp_line = {16{v.eip}};
    checkOutput("al.v", idx, 512'(al_o.v), 512'(v.ev));
    checkOutput("ic_adr", idx, 512'(ic_adr_o), 512'(v.eadr));
    checkOutput("fill_req", idx, 512'(fill_req_o), 512'(v.efreq));
    checkOutput("fill_adr", idx, 512'(fill_adr_o), 512'(v.efadr));
    checkOutput("miss_cnt", idx, 512'(miss_cnt_o), 512'(v.ecnt));
    if (v.ev) begin
      checkOutput("al.predict_taken", idx, 512'(al_o.predict_taken), 512'(v.ept));
      checkOutput("al.ip", idx, 512'(al_o.ip), 512'(v.eip));
      checkOutput("al.pip", idx, 512'(al_o.pip), 512'(v.epip));
      checkOutput("al.cacheline", idx, al_o.cacheline, exp_line);
    end
  endtask

  task automatic checkResetState(input int idx);
    checkOutput("rst.ic_adr", idx, 512'(ic_adr_o), 512'(32'hFFFC0100));
    checkOutput("rst.al", idx, 512'(al_o), 512'(0));
    checkOutput("rst.fill_req", idx, 512'(fill_req_o), 512'(0));
    checkOutput("rst.fill_adr", idx, 512'(fill_adr_o), 512'(0));
    checkOutput("rst.miss_cnt", idx, 512'(miss_cnt_o), 512'(0));
  endtask

  initial begin
    // rd rdip btb tgt hit done rdy | v pt al.ip al.pip ic_adr freq fill_adr cnt
    vecs[0]  = mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 32'hFFFC0100, 32'hFFFC0100, 32'hFFFC0104, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 32'hFFFC0104, 32'hFFFC0100, 32'hFFFC0108, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 32'hFFFC0108, 32'hFFFC0104, 32'hFFFC010C, 0, 0, 0);
    vecs[3]  = mk(1, 32'hFFFC0104, 1, 32'h00005000, 1, 0, 1, 0, 0, 0, 0, 32'hFFFC0104, 0, 0, 0);
    vecs[4]  = mk(0, 0, 1, 32'h00001000, 1, 0, 1, 1, 1, 32'hFFFC0104, 32'hFFFC0104, 32'h00001000, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 32'h00001000, 32'hFFFC0104, 32'h00001004, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 32'h00001000, 32'hFFFC0104, 32'h00001004, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 32'h00001000, 32'hFFFC0104, 32'h00001004, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 32'h00001000, 32'hFFFC0104, 32'h00001004, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 32'h00001004, 32'h00001000, 32'h00001008, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 32'h00001008, 32'h00001004, 32'h0000100C, 0, 0, 0);
    vecs[11] = mk(1, 32'h0000103C, 0, 0, 1, 0, 1, 0, 0, 0, 0, 32'h0000103C, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0000103C, 1, 32'h00001000, 1);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0000103C, 1, 32'h00001000, 1);
    vecs[14] = mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 32'h0000103C, 1, 32'h00001000, 1);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0000103C, 1, 32'h00001000, 1);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0000103C, 1, 32'h00001000, 1);
    vecs[17] = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 32'h0000103C, 0, 32'h00001000, 1);
    vecs[18] = mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 32'h0000103C, 32'h0000103C, 32'h00001040, 0, 32'h00001000, 1);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0000103C, 32'h0000103C, 32'h00001040, 1, 32'h00001040, 2);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0000103C, 32'h0000103C, 32'h00001040, 1, 32'h00001040, 2);
    vecs[21] = mk(1, 32'h00002000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00002000, 1, 32'h00001040, 2);
    vecs[22] = mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 32'h00002000, 1, 32'h00001040, 2);
    vecs[23] = mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 32'h00002000, 0, 32'h00001040, 2);
    vecs[24] = mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 32'h00002000, 32'h00002000, 32'h00002004, 0, 32'h00001040, 2);
    vecs[25] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h00002004, 1, 32'h00002000, 3);
    vecs[26] = mk(1, 32'hFFFFFFFC, 0, 0, 0, 1, 1, 0, 0, 0, 0, 32'hFFFFFFFC, 0, 32'h00002000, 3);
    vecs[27] = mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000000, 0, 32'h00002000, 3);
    vecs[28] = mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 32'h00000000, 32'hFFFFFFFC, 32'h00000004, 0, 32'h00002000, 3);
    vecs[29] = mk(0, 0, 0, 0, 1, 1, 1, 1, 0, 32'h00000004, 32'h00000000, 32'h00000008, 0, 32'h00002000, 3);
    vecs[30] = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 32'h00000004, 32'h00000000, 32'h00000008, 0, 32'h00002000, 3);

    rst_i = 1'b1;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk_i);
    checkResetState(-1);
    rst_i = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk_i);
      #1;
      checkVector(i, vecs[i]);
      @(negedge clk_i);
    end

    // Start a fill (held entry drains on the same cycle), then reset
    // asynchronously between edges: the request must drop at once.
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk_i);
    #1;
    checkOutput("midfill.fill_req", 100, 512'(fill_req_o), 512'(1));
    checkOutput("midfill.fill_adr", 100, 512'(fill_adr_o), 512'(32'h00000000));
    checkOutput("midfill.miss_cnt", 100, 512'(miss_cnt_o), 512'(4));
    checkOutput("midfill.al.v", 100, 512'(al_o.v), 512'(0));
    #2;
    rst_i = 1'b1;
    #1;
    checkResetState(101);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
